// File: rtl/alu_nibble_sequencer.sv
// Feeds a multi-nibble operation through a single 4-bit 74181-style ALU slice,
// least-significant nibble first, chaining the slice carry between nibbles.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic [3:0]             sel,
    input  logic                   mode,
    input  logic                   cin_n,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn4,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout_n,
    output logic                   zero,
    output logic                   busy,
    output logic                   done
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_n_q, cout_n_d;
    logic               zero_q, zero_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        index_d  = index_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_n_d = cout_n_q;
        zero_d   = zero_q;

        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = sel_q;
        alu_m  = mode_q;
        alu_cn = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sel_d   = sel;
                    mode_d  = mode;
                    cin_d   = cin_n;
                    index_d = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Nibble 0 takes the caller's carry; later nibbles take the previous slice carry-out.
                alu_cn = (index_q == '0) ? cin_q : carry_q;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (index_q == IDX_W'(i)) begin
                        alu_a            = a_q[4*i +: 4];
                        alu_b            = b_q[4*i +: 4];
                        result_d[4*i +: 4] = alu_f;
                    end
                end
                carry_d = alu_cn4;
                if (index_q == IDX_W'(NIBBLES - 1)) begin
                    cout_n_d = alu_cn4;
                    zero_d   = (result_d == '0);
                    state_d  = DONE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 4'h0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b1;
            index_q  <= '0;
            carry_q  <= 1'b1;
            result_q <= '0;
            cout_n_q <= 1'b1;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            cin_q    <= cin_d;
            index_q  <= index_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_n_q <= cout_n_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign cout_n = cout_n_q;
    assign zero   = zero_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (NIBBLES=2) with a behavioural
// 74181-style slice closing the loop on the ALU port.
module tb_alu_nibble_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] sel;
    logic       mode;
    logic       cin_n;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_m;
    logic       alu_cn;
    logic [3:0] alu_f;
    logic       alu_cn4;
    logic [7:0] result;
    logic       cout_n;
    logic       zero;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    alu_nibble_sequencer #(.NIBBLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .sel     (sel),
        .mode    (mode),
        .cin_n   (cin_n),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_m   (alu_m),
        .alu_cn  (alu_cn),
        .alu_f   (alu_f),
        .alu_cn4 (alu_cn4),
        .result  (result),
        .cout_n  (cout_n),
        .zero    (zero),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high data, active-low carries; only the functions this bench exercises.
    always_comb begin
        logic [4:0] sum;
        sum     = 5'd0;
        alu_f   = 4'h0;
        alu_cn4 = 1'b1;
        if (alu_m) begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b0011: alu_f = 4'h0;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                default: alu_f = ~alu_a;
            endcase
        end else begin
            case (alu_s)
                4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_cn};
                4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, ~alu_cn};
                default: sum = {1'b0, alu_a} + {4'b0, ~alu_cn};
            endcase
            alu_f   = sum[3:0];
            alu_cn4 = ~sum[4];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full operation: start pulse, two RUN cycles, then the DONE cycle.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] s, input logic m, input logic cin,
                                 input logic exp_cn1, input logic [7:0] exp_res,
                                 input logic exp_cout, input logic exp_zero);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sel   = s;
        mode  = m;
        cin_n = cin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        checkOutput({tag, " busy0"}, 32'(busy), 32'd1);
        checkOutput({tag, " a0"}, 32'(alu_a), 32'(a[3:0]));
        checkOutput({tag, " cn0"}, 32'(alu_cn), 32'(cin));
        @(negedge clk);
        checkOutput({tag, " busy1"}, 32'(busy), 32'd1);
        checkOutput({tag, " done_early"}, 32'(done), 32'd0);
        checkOutput({tag, " b1"}, 32'(alu_b), 32'(b[7:4]));
        checkOutput({tag, " cn1"}, 32'(alu_cn), 32'(exp_cn1));
        @(negedge clk);
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy_done"}, 32'(busy), 32'd0);
        checkOutput({tag, " result"}, 32'(result), 32'(exp_res));
        checkOutput({tag, " cout_n"}, 32'(cout_n), 32'(exp_cout));
        checkOutput({tag, " zero"}, 32'(zero), 32'(exp_zero));
    endtask

    initial begin
        int done_count;
        int first_done;
        int second_done;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        sel   = 4'h0;
        mode  = 1'b0;
        cin_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst result", 32'(result), 32'd0);
        checkOutput("rst cout_n", 32'(cout_n), 32'd1);
        checkOutput("rst zero", 32'(zero), 32'd0);
        checkOutput("rst alu_cn", 32'(alu_cn), 32'd1);
        checkOutput("rst alu_a", 32'(alu_a), 32'd0);
        rst = 1'b0;

        applyStimulus("add",    8'h3C, 8'h4B, 4'b1001, 1'b0, 1'b1, 1'b0, 8'h87, 1'b1, 1'b0);
        applyStimulus("addc",   8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus("sub",    8'h50, 8'h20, 4'b0110, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        applyStimulus("xor",    8'hA5, 8'hFF, 4'b0110, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        applyStimulus("zero",   8'h12, 8'h34, 4'b0011, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus("add11",  8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);

        // Restart request during RUN and DONE must be ignored.
        @(negedge clk);
        op_a = 8'h3C; op_b = 8'h4B; sel = 4'b1001; mode = 1'b0; cin_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        op_a = 8'h11; op_b = 8'h22;
        @(negedge clk);
        checkOutput("ign busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ign done", 32'(done), 32'd1);
        checkOutput("ign result", 32'(result), 32'h87);
        @(negedge clk);
        checkOutput("ign idle", 32'(busy), 32'd0);

        // Held start: one operation every four cycles.
        op_a = 8'hF0; op_b = 8'h20; sel = 4'b1001; mode = 1'b0; cin_n = 1'b1;
        start = 1'b1;
        done_count  = 0;
        first_done  = 0;
        second_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (done_count == 1) first_done = k;
                if (done_count == 2) second_done = k;
            end
        end
        start = 1'b0;
        checkOutput("held count", 32'(done_count), 32'd3);
        checkOutput("held first", 32'(first_done), 32'd3);
        checkOutput("held gap", 32'(second_done - first_done), 32'd4);
        checkOutput("held result", 32'(result), 32'h10);
        checkOutput("held cout_n", 32'(cout_n), 32'd0);

        // Abort in the second RUN cycle.
        @(negedge clk);
        op_a = 8'h3C; op_b = 8'h4B; sel = 4'b1001; mode = 1'b0; cin_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort run", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort result", 32'(result), 32'd0);
        checkOutput("abort cout_n", 32'(cout_n), 32'd1);
        @(negedge clk);
        checkOutput("abort nodone", 32'(done), 32'd0);

        applyStimulus("post",   8'h3C, 8'h4B, 4'b1001, 1'b0, 1'b1, 1'b0, 8'h87, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
